// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: arbiter state encoding,
// default word width and the parity modes understood by the transmitter.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    // Word width carried on tx_data (8 data bits + 1 extra, e.g. address flag).
    localparam int unsigned UART_DW = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_REQ     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2,
        PARITY_MARK = 2'd3
    } parity_mode_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Starting at rr_ptr_i and
// wrapping modulo NREQ, returns the first requester with its valid bit set.
//   req_valid_i : per-requester pending flags
//   rr_ptr_i    : index given highest priority this round
//   winner_o    : selected index (0 when nothing is pending)
//   any_valid_o : at least one requester pending
// ---------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IW-1:0]   rr_ptr_i,
    output logic [IW-1:0]   winner_o,
    output logic            any_valid_o
);

    logic [IW-1:0] cand;

    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(rr_ptr_i) + k) % NREQ);
            if (!any_valid_o && req_valid_i[cand]) begin
                winner_o    = cand;
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmitter among NREQ requesters.
// Latches the winning word, drives tx_request/tx_data, detects a fresh rising
// edge of the (asynchronous) tx_ack and returns a one-cycle req_ack pulse to
// the winner. A watchdog aborts a request the transmitter never acknowledges.
//   clk, reset   : clock, synchronous active-low reset
//   req_valid    : per-requester word pending
//   req_data     : packed words, requester i at [i*DW +: DW]
//   req_ack      : one-cycle pulse to the requester whose word was taken
//   tx_enable    : permits starting a new arbitration
//   tx_request   : request to transmitter (high in REQ)
//   tx_data      : latched word, stable while tx_request is high
//   tx_ack       : transmitter acknowledge, slow-domain level
//   tx_busy      : any state other than IDLE
//   grant_id     : index of current or last grant
//   timeout_err  : one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = UART_DW,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ack,
    input  logic                    tx_enable,
    output logic                    tx_request,
    output logic [DW-1:0]           tx_data,
    input  logic                    tx_ack,
    output logic                    tx_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    timeout_err
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned WW = $clog2(TIMEOUT);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [DW-1:0] data_q, data_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic          timeout_q, timeout_d;

    logic ack_meta_q, ack_s_q, ack_s_dly_q;
    logic ack_rise;

    logic [IW-1:0] pick_winner;
    logic          pick_any;
    logic [IW-1:0] next_ptr;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .winner_o    (pick_winner),
        .any_valid_o (pick_any)
    );

    // Two-flop synchronizer plus one delay stage for edge detection; a level
    // already high when REQ is entered never produces a rise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_meta_q  <= 1'b0;
            ack_s_q     <= 1'b0;
            ack_s_dly_q <= 1'b0;
        end else begin
            ack_meta_q  <= tx_ack;
            ack_s_q     <= ack_meta_q;
            ack_s_dly_q <= ack_s_q;
        end
    end

    assign ack_rise = ack_s_q & ~ack_s_dly_q;
    assign next_ptr = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        data_d    = data_q;
        wd_d      = wd_q;
        req_ack_d = '0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_enable && pick_any) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (pick_any) begin
                    grant_d = pick_winner;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (pick_winner == IW'(i)) begin
                            data_d = req_data[i*DW +: DW];
                        end
                    end
                    wd_d    = '0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_rise) begin
                    req_ack_d[grant_q] = 1'b1;
                    rr_ptr_d           = next_ptr;
                    state_d            = ST_RELEASE;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!ack_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            wd_q      <= '0;
            req_ack_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            wd_q      <= wd_d;
            req_ack_q <= req_ack_d;
            timeout_q <= timeout_d;
        end
    end

    assign tx_request  = (state_q == ST_REQ);
    assign tx_busy     = (state_q != ST_IDLE);
    assign tx_data     = data_q;
    assign grant_id    = grant_q;
    assign req_ack     = req_ack_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Scoreboard bench: the driver predicts each grant (id, word), ack and
// watchdog abort from a round-robin model and queues them; a monitor pops and
// compares whenever the arbiter raises tx_request, pulses req_ack or pulses
// timeout_err. A small transmitter model answers requests after a random delay.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 9;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]  req_ack;
    logic             tx_enable;
    logic             tx_request;
    logic [DW-1:0]    tx_data;
    logic             tx_ack;
    logic             tx_busy;
    logic [1:0]       grant_id;
    logic             timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_enable   (tx_enable),
        .tx_request  (tx_request),
        .tx_data     (tx_data),
        .tx_ack      (tx_ack),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } grant_t;

    grant_t exp_grant[$];
    int     exp_ack[$];
    int     exp_to[$];

    int vectors    = 0;
    int miscompares = 0;
    int cycles     = 0;
    int exp_ptr    = 0;
    bit auto_clr   = 1'b1;
    bit xm_on      = 1'b1;
    logic prev_req = 1'b0;
    grant_t mg;
    int     mid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got 'h%0h, expected none", name, act);
    endtask

    // Requesters drop their valid on the cycle they see their ack.
    task automatic step();
        @(negedge clk);
        cycles++;
        if (auto_clr) req_valid = req_valid & ~req_ack;
        if (cycles > 20000) begin
            $display("FAIL global_budget: got %0d cycles, expected < 20000", cycles);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    // Winner = pending index at smallest forward distance from the pointer.
    function automatic int pick(input logic [NREQ-1:0] set, input int ptr);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - ptr + NREQ) % NREQ;
            if (set[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic push_grant(input int id, input logic [DW-1:0] d);
        grant_t g;
        g.id   = id;
        g.data = d;
        exp_grant.push_back(g);
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    task automatic push_batch(input logic [NREQ-1:0] set);
        logic [NREQ-1:0] rem;
        int w;
        rem = set;
        for (int i = 0; i < NREQ; i++)
            if (set[i]) set_data(i, DW'($urandom));
        while (rem != 0) begin
            w = pick(rem, exp_ptr);
            push_grant(w, req_data[w*DW +: DW]);
            exp_ack.push_back(w);
            exp_ptr = (w + 1) % NREQ;
            rem[w]  = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(req_valid == '0 && !tx_busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) flag({name, "_timeout"}, 32'(req_valid));
        check({name, "_queues"}, exp_grant.size() + exp_ack.size() + exp_to.size(), 0);
    endtask

    task automatic wait_req(input string name, input int budget);
        int n;
        n = 0;
        while (!tx_request && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) flag({name, "_req_timeout"}, 32'(tx_request));
    endtask

    task automatic run_batch(input logic [NREQ-1:0] set, input int en_low);
        push_batch(set);
        tx_enable = (en_low == 0);
        req_valid = set;
        repeat (en_low) step();
        if (en_low > 0) check("enable_gate_busy", 32'(tx_busy), 0);
        tx_enable = 1'b1;
        wait_idle("batch", 600);
    endtask

    // Transmitter model: acks a request after 1..10 cycles, holds 4..8 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (xm_on && tx_request && !tx_ack) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                tx_ack = 1'b1;
                repeat ($urandom_range(4, 8)) @(negedge clk);
                tx_ack = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_request && !prev_req) begin
                if (exp_grant.size() == 0) flag("grant_unexpected", 32'(grant_id));
                else begin
                    mg = exp_grant.pop_front();
                    check("grant_id", 32'(grant_id), mg.id);
                    check("tx_data", 32'(tx_data), 32'(mg.data));
                end
            end
            if (req_ack != '0) begin
                if (exp_ack.size() == 0) flag("req_ack_unexpected", 32'(req_ack));
                else begin
                    mid = exp_ack.pop_front();
                    check("req_ack", 32'(req_ack), 32'(1) << mid);
                end
            end
            if (timeout_err) begin
                if (exp_to.size() == 0) flag("timeout_unexpected", 32'(grant_id));
                else begin
                    mid = exp_to.pop_front();
                    check("timeout_grant_id", 32'(grant_id), mid);
                end
            end
            prev_req = tx_request;
        end
    end

    initial begin
        int acks;
        int n;
        logic [DW-1:0] d;

        reset     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) set_data(i, DW'($urandom));
        tx_enable = 1'b1;
        tx_ack    = 1'b0;

        // Reset held with every requester pending.
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_tx_request", 32'(tx_request), 0);
            check("rst_ack_busy_to", 32'({req_ack, tx_busy, timeout_err}), 0);
            check("rst_grant_id", 32'(grant_id), 0);
            check("rst_tx_data", 32'(tx_data), 0);
        end
        req_valid = '0;
        reset     = 1'b1;
        step();

        // Single request: tx_request two cycles after valid.
        set_data(2, 9'h0A5);
        push_grant(2, 9'h0A5);
        exp_ack.push_back(2);
        exp_ptr   = 3;
        req_valid = 4'b0100;
        step();
        check("lat_arb_no_req", 32'(tx_request), 0);
        step();
        check("lat_req_high", 32'(tx_request), 1);
        wait_idle("single", 200);

        // Pointer now 3: {0,3} must go 3 then 0.
        run_batch(4'b1001, 0);

        // Round-robin from a fresh reset with everyone held valid.
        reset = 1'b0;
        step();
        reset   = 1'b1;
        exp_ptr = 0;
        auto_clr = 1'b0;
        for (int i = 0; i < NREQ; i++) set_data(i, DW'(9'h010 + i));
        for (int k = 0; k < 5; k++) begin
            push_grant(k % NREQ, DW'(9'h010 + (k % NREQ)));
            exp_ack.push_back(k % NREQ);
        end
        exp_ptr   = 1;
        req_valid = '1;
        acks = 0;
        n    = 0;
        while (acks < 5 && n < 400) begin
            step();
            n++;
            if (req_ack != '0) acks++;
        end
        if (acks < 5) flag("rr_ack_timeout", acks);
        req_valid = '0;
        auto_clr  = 1'b1;
        wait_idle("rr", 100);

        // Randomized request sets, sometimes with tx_enable held off first.
        for (int b = 0; b < 25; b++)
            run_batch(4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);

        // tx_enable gating in IDLE, then dropped during REQ.
        tx_enable = 1'b0;
        push_batch(4'b0001);
        req_valid = 4'b0001;
        repeat (6) step();
        check("gate_idle_busy", 32'(tx_busy), 0);
        check("gate_idle_req", 32'(tx_request), 0);
        tx_enable = 1'b1;
        wait_req("gate", 20);
        tx_enable = 1'b0;
        wait_idle("gate_inflight", 200);
        tx_enable = 1'b1;

        // Watchdog: transmitter silent.
        xm_on = 1'b0;
        d = DW'($urandom);
        set_data(1, d);
        push_grant(1, d);
        exp_to.push_back(1);
        exp_ptr   = 2;
        req_valid = 4'b0010;
        wait_req("wd", 20);
        n = 0;
        while (!timeout_err && n < 40) begin
            step();
            n++;
        end
        check("wd_pulse_delay", n, 16);
        check("wd_no_ack", 32'(req_ack), 0);
        req_valid = '0;
        step();
        check("wd_req_dropped", 32'(tx_request), 0);
        check("wd_pulse_width", 32'(timeout_err), 0);
        check("wd_queue", exp_to.size() + exp_grant.size(), 0);
        xm_on = 1'b1;
        run_batch(4'b0111, 0);

        // Stale ack: already high at REQ entry, needs fall then rise.
        xm_on  = 1'b0;
        tx_ack = 1'b1;
        repeat (3) step();
        push_batch(4'b1000);
        req_valid = 4'b1000;
        wait_req("stale", 20);
        acks = 0;
        repeat (5) begin
            step();
            if (req_ack != '0) acks++;
        end
        check("stale_no_ack", acks, 0);
        tx_ack = 1'b0;
        repeat (3) step();
        tx_ack = 1'b1;
        n = 0;
        while (req_ack == '0 && n < 10) begin
            step();
            n++;
        end
        check("stale_ack_latency", n, 3);
        tx_ack = 1'b0;
        wait_idle("stale", 50);

        // Reset during REQ: request drops, no ack, pointer cleared.
        d = DW'($urandom);
        set_data(0, d);
        push_grant(0, d);
        req_valid = 4'b0001;
        wait_req("mrst", 20);
        step();
        step();
        reset = 1'b0;
        step();
        check("mrst_tx_request", 32'(tx_request), 0);
        check("mrst_req_ack", 32'(req_ack), 0);
        check("mrst_busy", 32'(tx_busy), 0);
        check("mrst_grant_id", 32'(grant_id), 0);
        reset     = 1'b1;
        req_valid = '0;
        exp_ptr   = 0;
        repeat (3) step();
        check("mrst_queues", exp_grant.size() + exp_ack.size() + exp_to.size(), 0);
        xm_on = 1'b1;
        run_batch(4'b0011, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmitter among NREQ requesters. It latches one requester's 9-bit word, drives the transmitter's tx_request/tx_data handshake, and detects the transmitter's tx_ack. It then returns a one-cycle accept pulse to the winning requester. It sits between the host-side message sources and the transmitter, and adds a watchdog for a transmitter that never acknowledges.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 9, data width per word; matches transmitter tx_data
TIMEOUT, 4096, clk cycles to wait in REQ for tx_ack before aborting (>=16)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
req_valid  input  NREQ  per-requester word pending
req_data  input  NREQ*DW  packed words; requester i uses bits [i*DW +: DW]
req_ack  output  NREQ  one-cycle pulse: requester's word accepted by transmitter
tx_enable  input  1  high permits new arbitration
tx_request  output  1  to transmitter
tx_data  output  DW  to transmitter; held stable while tx_request high
tx_ack  input  1  from transmitter; slow-domain level, raised at START, dropped at BIT0
tx_busy  output  1  high in any state except IDLE
grant_id  output  clog2(NREQ)  index of current or last grant
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; rr_ptr=0; grant_id=0.
  - tx_request=0, tx_data=0, req_ack=0, tx_busy=0, timeout_err=0.
  - Ack sync flops cleared.
- Reset mid-transfer aborts immediately: no req_ack is issued, and tx_request drops on the following cycle.
- tx_ack passes through a 2-flop synchronizer into ack_s; ack_rise = ack_s & ~ack_s_d.
- States:
  - IDLE: if tx_enable && |req_valid, go to ARB.
  - ARB (1 cycle):
    - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
    - Latch tx_data=req_data[winner] and grant_id=winner; clear the watchdog; go to REQ.
    - If req_valid has meanwhile gone to 0, return to IDLE with no side effects.
  - REQ:
    - tx_request=1.
    - On ack_rise: req_ack[grant_id]=1 for exactly one cycle; rr_ptr=(grant_id+1) mod NREQ; go to RELEASE.
    - Otherwise watchdog++. When watchdog==TIMEOUT-1: timeout_err=1 for one cycle; rr_ptr=(grant_id+1) mod NREQ; no req_ack; go to IDLE.
  - RELEASE: tx_request=0; when ack_s==0, go to IDLE.
- Latency:
  - req_valid rising in IDLE -> tx_request high 2 cycles later (IDLE→ARB→REQ).
  - req_ack lags the transmitter's ack edge by 3 clk (2 sync + 1 registered).
- Requester rule:
  - Hold req_valid and data until req_ack.
  - Deasserting before the grant is legal.
  - After ARB, the latched word is used regardless of the requester's later inputs.
- tx_enable low: blocks only the IDLE→ARB transition; the in-flight REQ/RELEASE completes.
- A tx_ack already high on entry to REQ is not an edge; the block waits for a fresh rise.
- A single requester continuously valid is re-granted every word; there is no fairness penalty.
- At most one req_ack bit is high in any cycle.
- rr_ptr wraps NREQ-1 → 0.

Decomposition:
- Shared package uart_pkg:
  - State encoding (IDLE, ARB, REQ, RELEASE).
  - Default DW=9.
  - Parity mode constants shared with the transmitter.
- One natural sub-module: rr_pick, a combinational round-robin priority picker with inputs req_valid and rr_ptr and outputs winner index and any-valid.
- Synchronizer and watchdog stay inline.

Test Plan:
- Reset hold:
  - Stimulus: reset=0 for 3 cycles with req_valid=4'b1111.
  - Required: all outputs 0; tx_request never asserted; grant_id=0.
- Single request:
  - Stimulus: req_valid=4'b0100, data[2]=9'h0A5; model transmitter acks 10 cycles after tx_request.
  - Required: tx_request 2 cycles after valid, tx_data=9'h0A5; req_ack=4'b0100 one pulse; rr_ptr=3.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously, data i=9'h010+i.
  - Required: grant order 0,1,2,3,0; tx_data sequence 9'h010,011,012,013,010.
- tx_enable gating:
  - Stimulus: tx_enable=0 with req_valid=4'b0001.
  - Required: state stays IDLE, tx_busy=0.
  - Stimulus: drop tx_enable during REQ.
  - Required: the transfer completes with req_ack.
- Watchdog (TIMEOUT=16):
  - Stimulus: model never acks, req_valid=4'b0010.
  - Required: timeout_err pulse 16 cycles after REQ entry; no req_ack; tx_request=0 next cycle; next grant from index 2 onward.
- Stale ack and mid-transfer reset:
  - Stimulus: tx_ack held high on REQ entry.
  - Required: no req_ack until ack falls and rises again.
  - Stimulus: reset=0 during REQ.
  - Required: tx_request=0 next cycle; no req_ack.
